// File: rtl/mmio_event_bank_if.sv
// Data-memory bus slice seen by the MMIO event bank: write strobe, word
// address, write data, combinational window hit and registered read data.
interface mmio_event_bank_if;
  logic        wren;
  logic [11:0] address;
  logic [31:0] data;
  logic        hit;
  logic [31:0] q;

  modport master (output wren, address, data, input hit, q);
  modport slave  (input wren, address, data, output hit, q);
endinterface

// File: rtl/mmio_event_bank.sv
// 64-word MMIO window: read-only input words, read/write output words, and
// synchronised edge-detected event lines with sticky status, counters and irq.
module mmio_event_bank #(
  parameter logic [11:0] BASE  = 12'hF00,
  parameter int          N_IN  = 4,
  parameter int          N_OUT = 5,
  parameter int          N_EVT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mmio_event_bank_if.slave      bus,
  input  logic [32*N_IN-1:0]    in_words,
  output logic [32*N_OUT-1:0]   out_words,
  input  logic [N_EVT-1:0]      evt_in,
  output logic                  irq
);

  logic [5:0]  offset;
  logic [3:0]  idx;
  logic        wr;

  logic [31:0]                 q_q, rd_data;
  logic [N_OUT-1:0][31:0]      out_q, out_d;
  logic [N_EVT-1:0]            status_q, status_d;
  logic [N_EVT-1:0]            mask_q, mask_d;
  logic [N_EVT-1:0][7:0]       cnt_q, cnt_d;
  logic [N_EVT-1:0]            s1_q, s2_q, prev_q;
  logic [1:0]                  warm_q, warm_d;
  logic                        warm_done;
  logic [N_EVT-1:0]            evt_edge, w1c;

  assign offset    = bus.address[5:0];
  assign idx       = offset[3:0];
  assign bus.hit   = (bus.address[11:6] == BASE[11:6]);
  assign wr        = bus.wren && bus.hit;
  assign bus.q     = q_q;
  assign out_words = out_q;
  assign irq       = |(status_q & mask_q);

  // Edges are ignored for the first three cycles out of reset so a line
  // already high when reset drops is not counted as an event.
  assign warm_done = (warm_q == 2'd3);
  assign warm_d    = warm_done ? warm_q : warm_q + 2'd1;
  assign evt_edge  = s2_q & ~prev_q & {N_EVT{warm_done}};

  // Read mux works on pre-write state, so read-during-write returns old data.
  // NOTE: every always_comb output gets a default first; otherwise a path that skips the assignment infers a latch.
  always_comb begin
    rd_data = '0;
    case (offset[5:4])
      2'd0: for (int i = 0; i < N_IN; i++)
              if (idx == 4'(i)) rd_data = in_words[32*i +: 32];
      2'd1: for (int i = 0; i < N_OUT; i++)
              if (idx == 4'(i)) rd_data = out_q[i];
      2'd2: case (idx)
              4'd0:    rd_data[N_EVT-1:0] = status_q;
              4'd1:    rd_data[N_EVT-1:0] = mask_q;
              4'd2:    rd_data[N_EVT-1:0] = status_q & mask_q;
              default: rd_data = '0;
            endcase
      default: for (int i = 0; i < N_EVT; i++)
              if (idx == 4'(i)) rd_data[7:0] = cnt_q[i];
    endcase
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr && offset[5:4] == 2'd1) begin
      for (int i = 0; i < N_OUT; i++)
        if (idx == 4'(i)) out_d[i] = bus.data;
    end
    if (wr && offset == 6'h20) w1c    = bus.data[N_EVT-1:0];
    if (wr && offset == 6'h21) mask_d = bus.data[N_EVT-1:0];

    // A new edge beats a same-cycle W1C; a counter write beats a new edge.
    status_d = (status_q & ~w1c) | evt_edge;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_EVT; i++) begin
      if (wr && offset[5:4] == 2'd3 && idx == 4'(i))
        cnt_d[i] = 8'd0;
      else if (evt_edge[i] && cnt_q[i] != 8'hFF)
        cnt_d[i] = cnt_q[i] + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q      <= '0;
      // NOTE: the output words are a small flop array, not RAM, so they take a reset like any other register.
      out_q    <= '0;
      status_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      warm_q   <= '0;
    end else begin
      q_q      <= bus.hit ? rd_data : 32'd0;
      out_q    <= out_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      s1_q     <= evt_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      warm_q   <= warm_d;
    end
  end

endmodule

// File: tb/tb_mmio_event_bank.sv
// Self-checking bench for mmio_event_bank: directed scenarios followed by
// random bus/event traffic, all compared against a behavioural model.
module tb_mmio_event_bank;
  localparam logic [11:0] BASE  = 12'hF00;
  localparam int          N_IN  = 4;
  localparam int          N_OUT = 5;
  localparam int          N_EVT = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_IN-1:0][31:0]  in_w;
  logic [32*N_OUT-1:0]    out_w;
  logic [N_EVT-1:0]       evt;
  logic                   irq;

  mmio_event_bank_if bus ();

  mmio_event_bank #(.BASE(BASE), .N_IN(N_IN), .N_OUT(N_OUT), .N_EVT(N_EVT)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .in_words  (in_w),
    .out_words (out_w),
    .evt_in    (evt),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: register contents plus the history of sampled lines.
  logic [31:0]      out_m [N_OUT];
  logic [N_EVT-1:0] status_m, mask_m;
  int               cnt_m [N_EVT];
  logic [N_EVT-1:0] smp [$];   // smp[k] = evt_in sampled k edges ago
  int               n_edges;   // edges since reset was released

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_OUT; i++) out_m[i] = '0;
    for (int i = 0; i < N_EVT; i++) cnt_m[i] = 0;
    status_m = '0;
    mask_m   = '0;
    smp.delete();
    n_edges  = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] off);
    int i;
    i = int'(off[3:0]);
    case (off[5:4])
      2'd0: return (i < N_IN)  ? in_w[i]  : 32'd0;
      2'd1: return (i < N_OUT) ? out_m[i] : 32'd0;
      2'd2: begin
        if (i == 0) return 32'(status_m);
        if (i == 1) return 32'(mask_m);
        if (i == 2) return 32'(status_m & mask_m);
        return 32'd0;
      end
      default: return (i < N_EVT) ? 32'(cnt_m[i]) : 32'd0;
    endcase
  endfunction

  // Applies one clock edge worth of behaviour using the inputs present at that edge.
  task automatic model_edge();
    logic [N_EVT-1:0] rise, w1c, clr;
    logic [5:0]       off;
    int               i;
    if (reset) begin
      model_reset();
      return;
    end
    n_edges++;
    smp.push_front(evt);
    if (smp.size() > 4) void'(smp.pop_back());
    // A line high two samples ago and low three samples ago is a fresh event.
    rise = '0;
    if (n_edges >= 4) rise = smp[2] & ~smp[3];
    w1c = '0;
    clr = '0;
    if (bus.wren && bus.address[11:6] == BASE[11:6]) begin
      off = bus.address[5:0];
      i   = int'(off[3:0]);
      if (off[5:4] == 2'd1 && i < N_OUT) out_m[i] = bus.data;
      if (off == 6'h20) w1c = bus.data[N_EVT-1:0];
      if (off == 6'h21) mask_m = bus.data[N_EVT-1:0];
      if (off[5:4] == 2'd3 && i < N_EVT) clr[i] = 1'b1;
    end
    status_m = (status_m & ~w1c) | rise;
    for (int k = 0; k < N_EVT; k++) begin
      if (clr[k]) cnt_m[k] = 0;
      else if (rise[k] && cnt_m[k] < 255) cnt_m[k]++;
    end
  endtask

  task automatic step();
    logic        exp_hit;
    logic [31:0] exp_q;
    #1;
    exp_hit = (bus.address[11:6] == BASE[11:6]);
    check("hit", 32'(bus.hit), 32'(exp_hit));
    exp_q = (exp_hit && !reset) ? model_read(bus.address[5:0]) : 32'd0;
    @(posedge clock);
    #1;
    model_edge();
    check("q", bus.q, exp_q);
    for (int i = 0; i < N_OUT; i++) check("out_words", out_w[32*i +: 32], out_m[i]);
    check("irq", 32'(irq), 32'(|(status_m & mask_m)));
  endtask

  task automatic cyc(input logic w, input logic [11:0] a, input logic [31:0] d);
    bus.wren    = w;
    bus.address = a;
    bus.data    = d;
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus.wren = 1'b0; bus.address = '0; bus.data = '0;
    evt = '0;
    in_w = '0;
    model_reset();
    cyc(0, 12'h000, 0);
    cyc(0, 12'h000, 0);
    reset = 1'b0;

    // Every offset of the window reads zero after reset.
    for (int o = 0; o < 64; o++) begin
      cyc(0, BASE | 12'(o), 0);
      check("rst_read", bus.q, 32'd0);
    end
    check("rst_irq", 32'(irq), 32'd0);

    in_w[1] = 32'hDEAD_BEEF;
    cyc(0, 12'hF01, 0);
    check("in_word1", bus.q, 32'hDEAD_BEEF);

    cyc(1, 12'hF12, 32'h0000_0123);
    check("out2_write", out_w[95:64], 32'h123);
    cyc(1, 12'hF12, 32'h0000_0456);
    check("rdw_old", bus.q, 32'h123);
    cyc(0, 12'hF12, 0);
    check("rdw_new", bus.q, 32'h456);

    // Event on line 2, held for five cycles.
    evt = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 12'hF20, 0);
      if (k == 3) check("evt2_not_yet", bus.q, 32'd0);
      if (k == 4) check("evt2_status", bus.q, 32'h4);
    end
    check("irq_masked", 32'(irq), 32'd0);
    evt = '0;
    cyc(0, 12'hF32, 0);
    check("cnt2", bus.q, 32'd1);
    cyc(1, 12'hF21, 32'h4);
    check("irq_on", 32'(irq), 32'd1);
    cyc(1, 12'hF20, 32'h4);
    check("irq_w1c", 32'(irq), 32'd0);

    // Counter saturation on line 0.
    for (int k = 0; k < 300; k++) begin
      evt[0] = 1'b1; cyc(0, 12'hF00, 0);
      evt[0] = 1'b0; cyc(0, 12'hF00, 0);
    end
    for (int k = 0; k < 3; k++) cyc(0, 12'hF30, 0);
    check("cnt0_sat", bus.q, 32'd255);
    cyc(1, 12'hF30, 32'hFFFF_FFFF);
    cyc(0, 12'hF30, 0);
    check("cnt0_clear", bus.q, 32'd0);

    // Counter write lands on the same edge as a new event.
    evt[0] = 1'b1;
    cyc(0, 12'hF00, 0);
    cyc(0, 12'hF00, 0);
    cyc(1, 12'hF30, 0);
    cyc(0, 12'hF30, 0);
    check("cnt0_write_wins", bus.q, 32'd0);
    cyc(0, 12'hF20, 0);
    check("status0_set", bus.q & 32'h1, 32'h1);

    // W1C on status bit 1 in the same cycle as its edge.
    cyc(1, 12'hF20, 32'hF);
    evt[1] = 1'b1;
    cyc(0, 12'hF00, 0);
    cyc(0, 12'hF00, 0);
    cyc(1, 12'hF20, 32'h2);
    cyc(0, 12'hF20, 0);
    check("set_beats_w1c", bus.q & 32'h2, 32'h2);

    // Line 3 held high through reset never registers an event.
    evt = 4'b1000;
    reset = 1'b1;
    cyc(0, 12'hF00, 0);
    cyc(0, 12'hF00, 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) cyc(0, 12'hF20, 0);
    check("held_no_evt", bus.q & 32'h8, 32'd0);

    // Reset mid-stream wins over a concurrent write.
    cyc(1, 12'hF10, 32'd7);
    check("out0_seven", out_w[31:0], 32'd7);
    cyc(1, 12'hF21, 32'hF);
    reset = 1'b1;
    cyc(1, 12'hF10, 32'd9);
    check("rst_out0", out_w[31:0], 32'd0);
    check("rst_irq2", 32'(irq), 32'd0);
    reset = 1'b0;
    cyc(0, 12'hF21, 0);
    check("rst_mask", bus.q, 32'd0);
    cyc(0, 12'hF3F, 0);
    check("read_3f", bus.q, 32'd0);
    evt = '0;

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [11:0] a;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) evt[$urandom_range(0, N_EVT-1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) in_w[$urandom_range(0, N_IN-1)] = $urandom;
      if ($urandom_range(0, 4) == 0) a = 12'($urandom);
      else a = BASE | 12'($urandom_range(0, 63));
      cyc(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
